// File: rtl/alarm_timekeeper.sv
// rtl/alarm_timekeeper.sv - BCD time-of-day counter with alarm, auto-stop ring timer and optional snooze
// Optional feature macro: SNOOZE_EN (adds SNOOZED state and snooze down-counter).
module alarm_timekeeper #(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       set_time,
  input  logic       set_alarm,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic       alarm_en,
  input  logic       stop,
  input  logic       snooze,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic [7:0] alarm_hh,
  output logic [7:0] alarm_mm,
  output logic       ring
);

  localparam logic [7:0] LP_RING   = 8'(RING_SECONDS);
  localparam logic [9:0] LP_SNOOZE = 10'(SNOOZE_SECONDS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RINGING = 2'd1
`ifdef SNOOZE_EN
    ,S_SNOOZED = 2'd2
`endif
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_hh, r_mm, r_ss;
  logic [7:0] r_alarm_hh, r_alarm_mm;
  logic [7:0] r_ring_cnt;
  logic [7:0] w_ring_cnt_nxt;
  logic       w_set_valid;
  logic       w_adv;
  logic       w_match;
  logic [7:0] w_hh_next, w_mm_next, w_ss_next;
`ifdef SNOOZE_EN
  logic [9:0] r_snz_cnt;
  logic [9:0] w_snz_cnt_nxt;
`else
  logic       w_unused;
  assign w_unused = snooze ^ LP_SNOOZE[0];
`endif

  // Digit-wise BCD increment; callers handle the 59/23 rollover.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) bcd_inc = {v[7:4] + 4'd1, 4'd0};
    else                bcd_inc = {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_comb begin
    w_set_valid = ((set_hh[7:4] < 4'd2 && set_hh[3:0] <= 4'd9) ||
                   (set_hh[7:4] == 4'd2 && set_hh[3:0] <= 4'd3)) &&
                  (set_mm[7:4] <= 4'd5) && (set_mm[3:0] <= 4'd9);
  end

  always_comb begin
    w_adv     = tick & ~set_time;
    w_ss_next = (r_ss == 8'h59) ? 8'h00 : bcd_inc(r_ss);
    w_mm_next = r_mm;
    w_hh_next = r_hh;
    if (r_ss == 8'h59) begin
      w_mm_next = (r_mm == 8'h59) ? 8'h00 : bcd_inc(r_mm);
      if (r_mm == 8'h59) w_hh_next = (r_hh == 8'h23) ? 8'h00 : bcd_inc(r_hh);
    end
    // Only a tick-driven arrival at hh:mm:00 fires; stop vetoes a fresh trigger.
    w_match = w_adv && alarm_en && !stop &&
              (w_hh_next == r_alarm_hh) && (w_mm_next == r_alarm_mm) &&
              (w_ss_next == 8'h00);
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ring_cnt_nxt = r_ring_cnt;
`ifdef SNOOZE_EN
    w_snz_cnt_nxt  = r_snz_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_match) begin
          w_state_nxt    = S_RINGING;
          w_ring_cnt_nxt = 8'd0;
        end
      end
      S_RINGING: begin
        if (stop) begin
          w_state_nxt    = S_IDLE;
          w_ring_cnt_nxt = 8'd0;
`ifdef SNOOZE_EN
        end else if (snooze) begin
          w_state_nxt   = S_SNOOZED;
          w_snz_cnt_nxt = LP_SNOOZE;
`endif
        end else if (tick) begin
          if (r_ring_cnt + 8'd1 == LP_RING) begin
            w_state_nxt    = S_IDLE;
            w_ring_cnt_nxt = 8'd0;
          end else begin
            w_ring_cnt_nxt = r_ring_cnt + 8'd1;
          end
        end
      end
`ifdef SNOOZE_EN
      S_SNOOZED: begin
        if (stop) begin
          w_state_nxt   = S_IDLE;
          w_snz_cnt_nxt = 10'd0;
        end else if (tick) begin
          if (r_snz_cnt <= 10'd1) begin
            w_state_nxt    = S_RINGING;
            w_ring_cnt_nxt = 8'd0;
            w_snz_cnt_nxt  = 10'd0;
          end else begin
            w_snz_cnt_nxt = r_snz_cnt - 10'd1;
          end
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
    if (!alarm_en) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hh       <= 8'h00;
      r_mm       <= 8'h00;
      r_ss       <= 8'h00;
      r_alarm_hh <= 8'h00;
      r_alarm_mm <= 8'h00;
      r_state    <= S_IDLE;
      r_ring_cnt <= 8'd0;
`ifdef SNOOZE_EN
      r_snz_cnt  <= 10'd0;
`endif
    end else begin
      if (set_time) begin
        if (w_set_valid) begin
          r_hh <= set_hh;
          r_mm <= set_mm;
          r_ss <= 8'h00;
        end
      end else if (tick) begin
        r_hh <= w_hh_next;
        r_mm <= w_mm_next;
        r_ss <= w_ss_next;
      end
      if (set_alarm && w_set_valid) begin
        r_alarm_hh <= set_hh;
        r_alarm_mm <= set_mm;
      end
      r_state    <= w_state_nxt;
      r_ring_cnt <= w_ring_cnt_nxt;
`ifdef SNOOZE_EN
      r_snz_cnt  <= w_snz_cnt_nxt;
`endif
    end
  end

  assign hh       = r_hh;
  assign mm       = r_mm;
  assign ss       = r_ss;
  assign alarm_hh = r_alarm_hh;
  assign alarm_mm = r_alarm_mm;
  assign ring     = (r_state == S_RINGING);

endmodule

// File: tb/tb_alarm_timekeeper.sv
// tb/tb_alarm_timekeeper.sv - directed self-checking bench for alarm_timekeeper
module tb_alarm_timekeeper;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0, set_time = 1'b0, set_alarm = 1'b0;
  logic [7:0] set_hh = 8'h00, set_mm = 8'h00;
  logic       alarm_en = 1'b0, stop = 1'b0, snooze = 1'b0;
  logic [7:0] hh, mm, ss, alarm_hh, alarm_mm;
  logic       ring;
  int         n_checks = 0;
  int         n_fail = 0;

  alarm_timekeeper #(.RING_SECONDS(60), .SNOOZE_SECONDS(5)) dut (
    .clk(clk), .rst(rst), .tick(tick), .set_time(set_time), .set_alarm(set_alarm),
    .set_hh(set_hh), .set_mm(set_mm), .alarm_en(alarm_en), .stop(stop), .snooze(snooze),
    .hh(hh), .mm(mm), .ss(ss), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .ring(ring)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) cyc();
    tick = 1'b0;
  endtask

  task automatic load_time(input logic [7:0] h, input logic [7:0] m);
    set_hh = h; set_mm = m; set_time = 1'b1;
    cyc();
    set_time = 1'b0;
  endtask

  task automatic load_alarm(input logic [7:0] h, input logic [7:0] m);
    set_hh = h; set_mm = m; set_alarm = 1'b1;
    cyc();
    set_alarm = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    n_checks++;
    if ({hh, mm, ss, alarm_hh, alarm_mm} !== 40'h0 || ring !== 1'b0) begin
      $display("FAIL reset got %h%h%h al %h%h ring %b exp 000000 al 0000 ring 0", hh, mm, ss, alarm_hh, alarm_mm, ring);
      n_fail++;
    end
  endtask

  task automatic test_wrap();
    load_time(8'h23, 8'h59);
    n_checks++;
    if ({hh, mm, ss} !== 24'h235900) begin
      $display("FAIL wrap_load got %h exp 235900", {hh, mm, ss}); n_fail++;
    end
    ticks(59);
    n_checks++;
    if ({hh, mm, ss} !== 24'h235959) begin
      $display("FAIL wrap_59 got %h exp 235959", {hh, mm, ss}); n_fail++;
    end
    ticks(1);
    n_checks++;
    if ({hh, mm, ss} !== 24'h000000) begin
      $display("FAIL wrap_midnight got %h exp 000000", {hh, mm, ss}); n_fail++;
    end
    load_time(8'h09, 8'h09);
    ticks(61);
    n_checks++;
    if ({hh, mm, ss} !== 24'h091001) begin
      $display("FAIL carry_digit got %h exp 091001", {hh, mm, ss}); n_fail++;
    end
  endtask

  task automatic test_invalid_set();
    load_time(8'h12, 8'h34);
    ticks(2);
    load_time(8'h24, 8'h00);
    n_checks++;
    if ({hh, mm, ss} !== 24'h123402) begin
      $display("FAIL bad_hh got %h exp 123402", {hh, mm, ss}); n_fail++;
    end
    load_time(8'h12, 8'h5A);
    n_checks++;
    if ({hh, mm, ss} !== 24'h123402) begin
      $display("FAIL bad_mm got %h exp 123402", {hh, mm, ss}); n_fail++;
    end
    load_alarm(8'h1A, 8'h00);
    n_checks++;
    if ({alarm_hh, alarm_mm} !== 16'h0000) begin
      $display("FAIL bad_alarm got %h exp 0000", {alarm_hh, alarm_mm}); n_fail++;
    end
    tick = 1'b1;
    load_time(8'h12, 8'h00);
    tick = 1'b0;
    n_checks++;
    if ({hh, mm, ss} !== 24'h120000) begin
      $display("FAIL set_vs_tick got %h exp 120000", {hh, mm, ss}); n_fail++;
    end
  endtask

  task automatic test_both_sets();
    set_time = 1'b1;
    load_alarm(8'h10, 8'h15);
    set_time = 1'b0;
    n_checks++;
    if ({hh, mm, ss, alarm_hh, alarm_mm} !== 40'h1015001015) begin
      $display("FAIL both_sets got %h%h%h al %h%h exp 101500 al 1015", hh, mm, ss, alarm_hh, alarm_mm); n_fail++;
    end
  endtask

  task automatic test_alarm_ring();
    load_alarm(8'h07, 8'h30);
    alarm_en = 1'b1;
    load_time(8'h07, 8'h29);
    ticks(59);
    n_checks++;
    if (ring !== 1'b0 || {hh, mm, ss} !== 24'h072959) begin
      $display("FAIL pre_alarm got ring %b t %h exp ring 0 t 072959", ring, {hh, mm, ss}); n_fail++;
    end
    ticks(1);
    n_checks++;
    if (ring !== 1'b1 || {hh, mm, ss} !== 24'h073000) begin
      $display("FAIL alarm_rise got ring %b t %h exp ring 1 t 073000", ring, {hh, mm, ss}); n_fail++;
    end
    ticks(59);
    n_checks++;
    if (ring !== 1'b1) begin
      $display("FAIL ring_hold got %b exp 1", ring); n_fail++;
    end
    ticks(1);
    n_checks++;
    if (ring !== 1'b0) begin
      $display("FAIL ring_timeout got %b exp 0", ring); n_fail++;
    end
    ticks(3);
    n_checks++;
    if (ring !== 1'b0 || {alarm_hh, alarm_mm} !== 16'h0730) begin
      $display("FAIL after_timeout got ring %b al %h exp ring 0 al 0730", ring, {alarm_hh, alarm_mm}); n_fail++;
    end
  endtask

  task automatic test_set_on_alarm();
    load_alarm(8'h06, 8'h00);
    load_time(8'h06, 8'h00);
    n_checks++;
    if (ring !== 1'b0) begin
      $display("FAIL set_on_alarm got %b exp 0", ring); n_fail++;
    end
    ticks(1);
    n_checks++;
    if (ring !== 1'b0) begin
      $display("FAIL set_on_alarm_tick got %b exp 0", ring); n_fail++;
    end
  endtask

  task automatic test_stop();
    load_time(8'h05, 8'h59);
    ticks(60);
    n_checks++;
    if (ring !== 1'b1) begin
      $display("FAIL stop_pre got %b exp 1", ring); n_fail++;
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    n_checks++;
    if (ring !== 1'b0) begin
      $display("FAIL stop_edge got %b exp 0", ring); n_fail++;
    end
    ticks(5);
    n_checks++;
    if (ring !== 1'b0 || {hh, mm, ss} !== 24'h060005) begin
      $display("FAIL stop_hold got ring %b t %h exp ring 0 t 060005", ring, {hh, mm, ss}); n_fail++;
    end
  endtask

  task automatic test_snooze();
    load_alarm(8'h09, 8'h00);
    load_time(8'h08, 8'h59);
    ticks(60);
    n_checks++;
    if (ring !== 1'b1) begin
      $display("FAIL snooze_pre got %b exp 1", ring); n_fail++;
    end
    snooze = 1'b1;
    cyc();
    snooze = 1'b0;
`ifdef SNOOZE_EN
    n_checks++;
    if (ring !== 1'b0) begin
      $display("FAIL snooze_quiet got %b exp 0", ring); n_fail++;
    end
    ticks(4);
    n_checks++;
    if (ring !== 1'b0) begin
      $display("FAIL snooze_4 got %b exp 0", ring); n_fail++;
    end
`else
    n_checks++;
    if (ring !== 1'b1) begin
      $display("FAIL snooze_ignored got %b exp 1", ring); n_fail++;
    end
    ticks(4);
`endif
    ticks(1);
    n_checks++;
    if (ring !== 1'b1) begin
      $display("FAIL snooze_resume got %b exp 1", ring); n_fail++;
    end
    alarm_en = 1'b0;
    cyc();
    n_checks++;
    if (ring !== 1'b0) begin
      $display("FAIL alarm_en_off got %b exp 0", ring); n_fail++;
    end
    alarm_en = 1'b1;
  endtask

  task automatic test_rst_mid_ring();
    load_alarm(8'h07, 8'h30);
    load_time(8'h07, 8'h29);
    ticks(70);
    n_checks++;
    if (ring !== 1'b1 || {hh, mm, ss} !== 24'h073010) begin
      $display("FAIL rst_pre got ring %b t %h exp ring 1 t 073010", ring, {hh, mm, ss}); n_fail++;
    end
    rst = 1'b1;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    rst = 1'b0;
    n_checks++;
    if ({hh, mm, ss, alarm_hh, alarm_mm} !== 40'h0 || ring !== 1'b0) begin
      $display("FAIL rst_ring got %h%h%h al %h%h ring %b exp all 0", hh, mm, ss, alarm_hh, alarm_mm, ring); n_fail++;
    end
    ticks(3);
    n_checks++;
    if ({hh, mm, ss} !== 24'h000003 || ring !== 1'b0) begin
      $display("FAIL rst_recount got t %h ring %b exp t 000003 ring 0", {hh, mm, ss}, ring); n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_invalid_set();
    test_both_sets();
    test_alarm_ring();
    test_set_on_alarm();
    test_stop();
    test_snooze();
    test_rst_mid_ring();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
